// File: rtl/peripheral_responder_pkg.sv
// Shared definitions for the MEM-stage peripheral window: register word indices,
// TCON bit positions and reset constants.
package peripheral_responder_pkg;

  localparam int REG_NUM = 6;

  typedef enum logic [2:0] {
    REG_TH      = 3'd0,
    REG_TL      = 3'd1,
    REG_TCON    = 3'd2,
    REG_LED     = 3'd3,
    REG_DIGI    = 3'd4,
    REG_SYSTICK = 3'd5
  } reg_sel_e;

  localparam int TCON_EN     = 0;
  localparam int TCON_IRQ_EN = 1;
  localparam int TCON_IRQ_ST = 2;

  // Anodes are active-low, so all four off with segments cleared.
  localparam logic [11:0] DIGI_RST = 12'hF00;

  function automatic logic is_reg(input logic [2:0] idx);
    return idx <= 3'(REG_NUM - 1);
  endfunction

endpackage

// File: rtl/peripheral_responder_timer.sv
// Reloadable up-counting timer: TH reload, TL counter, TCON control/status and
// a level interrupt that stays up until software clears the status bit.
module peripheral_responder_timer
  import peripheral_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we_th,
  input  logic        i_we_tl,
  input  logic        i_we_tcon,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_th,
  output logic [31:0] o_tl,
  output logic [2:0]  o_tcon,
  output logic        o_irq
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic        w_overflow;

  assign w_overflow = r_tcon[TCON_EN] && (r_tl == 32'hFFFF_FFFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_th   <= 32'd0;
      r_tl   <= 32'd0;
      r_tcon <= 3'd0;
    end else begin
      if (i_we_th)
        r_th <= i_wdata;

      // A CPU write to TL wins; the reload samples TH before any same-cycle write.
      if (i_we_tl)
        r_tl <= i_wdata;
      else if (r_tcon[TCON_EN])
        r_tl <= w_overflow ? r_th : r_tl + 32'd1;

      if (i_we_tcon) begin
        r_tcon[TCON_EN]     <= i_wdata[TCON_EN];
        r_tcon[TCON_IRQ_EN] <= i_wdata[TCON_IRQ_EN];
      end

      // Set beats clear so an overflow coinciding with a status clear is not lost.
      if (w_overflow && r_tcon[TCON_IRQ_EN])
        r_tcon[TCON_IRQ_ST] <= 1'b1;
      else if (i_we_tcon)
        r_tcon[TCON_IRQ_ST] <= i_wdata[TCON_IRQ_ST];
    end
  end

  assign o_th   = r_th;
  assign o_tl   = r_tl;
  assign o_tcon = r_tcon;
  assign o_irq  = r_tcon[TCON_IRQ_EN] & r_tcon[TCON_IRQ_ST];

endmodule

// File: rtl/peripheral_responder.sv
// Peripheral slave beside DataMem: window decode, zero-latency read mux, LED,
// raw 7-segment and SysTick registers, plus the timer sub-block.
module peripheral_responder
  import peripheral_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Address,
  input  logic [31:0]      Write_data,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic [31:0]      Mem_data,
  output logic             hit,
  output logic             irq,
  output logic [LED_W-1:0] leds,
  output logic [3:0]       an,
  output logic [7:0]       seg
);

  logic [LED_W-1:0] r_led;
  logic [11:0]      r_digi;
  logic [31:0]      r_systick;

  logic [2:0]  w_idx;
  logic        w_hit;
  logic        w_wr;
  logic [31:0] w_th;
  logic [31:0] w_tl;
  logic [2:0]  w_tcon;
  logic        w_unused;

  // Byte lane bits are meaningless on this word-only bus.
  assign w_unused = ^Address[1:0];

  assign w_idx = Address[4:2];
  assign w_hit = (Address[31:5] == BASE_ADDR[31:5]) && is_reg(w_idx);
  assign w_wr  = w_hit && MemWrite;
  assign hit   = w_hit;

  peripheral_responder_timer u_timer (
    .clk       (clk),
    .rst_n     (reset),
    .i_we_th   (w_wr && (w_idx == REG_TH)),
    .i_we_tl   (w_wr && (w_idx == REG_TL)),
    .i_we_tcon (w_wr && (w_idx == REG_TCON)),
    .i_wdata   (Write_data),
    .o_th      (w_th),
    .o_tl      (w_tl),
    .o_tcon    (w_tcon),
    .o_irq     (irq)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led     <= '0;
      r_digi    <= DIGI_RST;
      r_systick <= 32'd0;
    end else begin
      if (w_wr && (w_idx == REG_LED))
        r_led <= Write_data[LED_W-1:0];
      if (w_wr && (w_idx == REG_DIGI))
        r_digi <= Write_data[11:0];
      if (w_wr && (w_idx == REG_SYSTICK))
        r_systick <= Write_data;
      else
        r_systick <= r_systick + 32'd1;
    end
  end

  // Reads see the register state before any write committing on this edge.
  always_comb begin
    Mem_data = 32'd0;
    if (w_hit && MemRead) begin
      case (w_idx)
        REG_TH:      Mem_data = w_th;
        REG_TL:      Mem_data = w_tl;
        REG_TCON:    Mem_data = {29'd0, w_tcon};
        REG_LED:     Mem_data = 32'(r_led);
        REG_DIGI:    Mem_data = {20'd0, r_digi};
        REG_SYSTICK: Mem_data = r_systick;
        default:     Mem_data = 32'd0;
      endcase
    end
  end

  assign leds = r_led;
  assign an   = r_digi[11:8];
  assign seg  = r_digi[7:0];

endmodule
